// File: rtl/ttl_serial_pkg.sv
// Shared types and constants for the 74165-style parallel-in/serial-out reader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ttl_serial_pkg;

  // Frame length in bits; the port list is fixed to eight lines A..H.
  localparam int WIDTH = 8;

  // Width of the bit and period counters (period counter must reach 254).
  localparam int CNT_W = 8;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/ttl_74165_core.sv
// 74165-style 8-bit register: parallel load, one-step shift with cascade input.
// Latency: load/shift take effect at the clock edge; QH reflects the register end stage.
// Backpressure: none; shift_en low (clock inhibit) simply holds the register.
module ttl_74165_core
  import ttl_serial_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_shift_en,
  input  logic             i_ser,
  input  logic             i_direction,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_qh,
  output logic             o_qh_n
);

  logic [WIDTH-1:0] r_sr;

  // Register: reset clears, load latches the lines, shift moves one place and pulls in SER.
  // direction=1 shifts toward the MSB (H out first, SER enters at A);
  // direction=0 shifts toward the LSB (A out first, SER enters at H).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_d;
    end else if (i_shift_en) begin
      if (i_direction) begin
        r_sr <= {r_sr[WIDTH-2:0], i_ser};
      end else begin
        r_sr <= {i_ser, r_sr[WIDTH-1:1]};
      end
    end
  end

  // The output stage is a flop of the register, so A..H never reach QH combinationally.
  assign o_qh   = i_direction ? r_sr[WIDTH-1] : r_sr[0];
  assign o_qh_n = ~o_qh;

endmodule

// File: rtl/ttl_74165_serializer.sv
// Captures lines A..H on START and shifts them out on QH, BIT_CYCLES clocks per bit.
// Latency: first bit on QH 1 cycle after START; DONE pulses WIDTH*BIT_CYCLES+1 cycles after START.
// Backpressure: CLK_INH freezes shifting and pacing; START is ignored (not queued) unless IDLE.
module ttl_74165_serializer #(
  parameter int WIDTH      = 8,    // only 8 is supported by the fixed port list
  parameter int BIT_CYCLES = 1,    // 1..255 clocks per bit on QH
  parameter bit MSB_FIRST  = 1'b1  // 1: H first (classic 74165), 0: A first
) (
  input  logic CLK,
  input  logic RESET,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  input  logic E,
  input  logic F,
  input  logic G,
  input  logic H,
  input  logic SER,
  input  logic START,
  input  logic CLK_INH,
  output logic QH,
  output logic QH_N,
  output logic BUSY,
  output logic DONE
);

  import ttl_serial_pkg::*;

  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] r_per_cnt;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_bit_nxt;
  logic [CNT_W-1:0] w_per_nxt;
  logic             w_load;
  logic             w_shift;
  logic [7:0]       w_lines;

  assign w_lines = {H, G, F, E, D, C, B, A};

  // State and counter registers; RESET abandons any frame in progress.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_per_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_per_cnt <= w_per_nxt;
    end
  end

  // Next state, pacing counters and core controls. The last bit's period wrap ends the
  // frame without shifting, so QH keeps showing the final bit through DONE and IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit_cnt;
    w_per_nxt   = r_per_cnt;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    BUSY        = 1'b0;
    DONE        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
          w_bit_nxt   = '0;
          w_per_nxt   = '0;
        end
      end
      ST_SHIFT: begin
        BUSY = 1'b1;
        if (!CLK_INH) begin
          if (r_per_cnt == PER_LAST) begin
            w_per_nxt = '0;
            if (r_bit_cnt == BIT_LAST) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_shift   = 1'b1;
              w_bit_nxt = r_bit_cnt + CNT_W'(1);
            end
          end else begin
            w_per_nxt = r_per_cnt + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        DONE        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  ttl_74165_core u_core (
    .i_clk       (CLK),
    .i_rst       (RESET),
    .i_load      (w_load),
    .i_shift_en  (w_shift),
    .i_ser       (SER),
    .i_direction (MSB_FIRST),
    .i_d         (w_lines),
    .o_qh        (QH),
    .o_qh_n      (QH_N)
  );

endmodule

// File: tb/tb_ttl_74165_serializer.sv
// Self-checking bench: two serializers (1 clk/bit MSB-first, 3 clk/bit LSB-first) against a frame model.
// Latency: expectations are queued per cycle and compared #1 after the following rising edge.
// Backpressure: CLK_INH pauses the model's pacing exactly as it pauses the DUT.
module tb_ttl_74165_serializer;

  logic CLK = 1'b0;
  logic RESET, A, B, C, D, E, F, G, H, SER, CLK_INH;
  logic start0, start1;
  logic qh0, qhn0, busy0, done0;
  logic qh1, qhn1, busy1, done1;

  typedef struct packed {
    logic sel;
    logic qh;
    logic busy;
    logic done;
  } exp_t;

  exp_t q_exp[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  always #5 CLK = ~CLK;

  ttl_74165_serializer #(.WIDTH(8), .BIT_CYCLES(1), .MSB_FIRST(1'b1)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H),
    .SER(SER), .START(start0), .CLK_INH(CLK_INH),
    .QH(qh0), .QH_N(qhn0), .BUSY(busy0), .DONE(done0)
  );

  ttl_74165_serializer #(.WIDTH(8), .BIT_CYCLES(3), .MSB_FIRST(1'b0)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H),
    .SER(SER), .START(start1), .CLK_INH(CLK_INH),
    .QH(qh1), .QH_N(qhn1), .BUSY(busy1), .DONE(done1)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  task automatic expect_out(input logic sel, input logic qh, input logic busy, input logic done);
    exp_t e;
    e.sel  = sel;
    e.qh   = qh;
    e.busy = busy;
    e.done = done;
    q_exp.push_back(e);
  endtask

  // Advance one clock, then compare every expectation queued for this cycle.
  task automatic step_cycle();
    exp_t e;
    logic o_qh, o_qhn, o_busy, o_done;
    @(posedge CLK);
    #1;
    cyc++;
    while (q_exp.size() > 0) begin
      e      = q_exp.pop_front();
      o_qh   = e.sel ? qh1   : qh0;
      o_qhn  = e.sel ? qhn1  : qhn0;
      o_busy = e.sel ? busy1 : busy0;
      o_done = e.sel ? done1 : done0;
      chk($sformatf("dut%0d qh c%0d", e.sel, cyc), o_qh, e.qh);
      chk($sformatf("dut%0d qh_n c%0d", e.sel, cyc), o_qhn, ~e.qh);
      chk($sformatf("dut%0d busy c%0d", e.sel, cyc), o_busy, e.busy);
      chk($sformatf("dut%0d done c%0d", e.sel, cyc), o_done, e.done);
    end
  endtask

  // Bit b of a frame in transmit order; data is {H..A}.
  function automatic logic bit_of(input logic sel, input logic [7:0] data, input int b);
    logic [7:0] v;
    v = data;
    return sel ? v[b] : v[7-b];
  endfunction

  task automatic set_lines(input logic [7:0] v);
    {H, G, F, E, D, C, B, A} = v;
  endtask

  task automatic drive_start(input logic sel, input logic v);
    if (sel) start1 = v;
    else     start0 = v;
  endtask

  // One full frame from IDLE: START edge, pacing with optional inhibit, DONE, one IDLE cycle.
  // inh_bit/inh_len: hold CLK_INH for inh_len edges at the start of bit inh_bit (-1: none).
  // hold: keep START high throughout; mid: raise START during bit 2 (must be ignored).
  task automatic run_frame(input logic sel, input logic [7:0] data, input int inh_bit,
                           input int inh_len, input bit hold, input bit mid);
    int   bc;
    int   b;
    int   p;
    int   inh_left;
    logic inh;
    bc       = sel ? 3 : 1;
    b        = 0;
    p        = 0;
    inh_left = inh_len;
    set_lines(data);
    CLK_INH  = (inh_len > 0);  // loading is not inhibited
    SER      = 1'($urandom);
    drive_start(sel, 1'b1);
    expect_out(sel, bit_of(sel, data, 0), 1'b1, 1'b0);
    step_cycle();
    while (b < 8) begin
      inh = (b == inh_bit) && (p == 0) && (inh_left > 0);
      drive_start(sel, hold || (mid && b == 2));
      CLK_INH = inh;
      SER     = 1'($urandom);
      set_lines(8'($urandom));  // lines after the latch must not matter
      if (inh) begin
        inh_left--;
      end else begin
        p++;
        if (p == bc) begin
          p = 0;
          b++;
        end
      end
      if (b == 8) expect_out(sel, bit_of(sel, data, 7), 1'b0, 1'b1);
      else        expect_out(sel, bit_of(sel, data, b), 1'b1, 1'b0);
      step_cycle();
    end
    drive_start(sel, hold);
    CLK_INH = 1'b0;
    expect_out(sel, bit_of(sel, data, 7), 1'b0, 1'b0);
    step_cycle();
  endtask

  initial begin
    logic [7:0] data;
    RESET   = 1'b1;
    start0  = 1'b1;
    start1  = 1'b1;
    CLK_INH = 1'b0;
    SER     = 1'b0;
    set_lines(8'hFF);

    // Reset dominates START and all-ones lines.
    repeat (2) begin
      expect_out(1'b0, 1'b0, 1'b0, 1'b0);
      expect_out(1'b1, 1'b0, 1'b0, 1'b0);
      step_cycle();
    end
    RESET  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    expect_out(1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(1'b1, 1'b0, 1'b0, 1'b0);
    step_cycle();

    // Basic MSB-first frame, then LSB-first paced frame (DONE at cycle 25).
    run_frame(1'b0, 8'hB2, -1, 0, 1'b0, 1'b0);
    run_frame(1'b1, 8'h83, -1, 0, 1'b0, 1'b0);

    // Inhibit for 4 edges at the 4th bit: DONE lands at cycle 13.
    run_frame(1'b0, 8'hA5, 3, 4, 1'b0, 1'b0);
    // Inhibit on the paced instance, including CLK_INH high at the START edge.
    run_frame(1'b1, 8'h4D, 5, 2, 1'b0, 1'b0);

    // START mid-frame is ignored.
    run_frame(1'b0, 8'h6E, -1, 0, 1'b0, 1'b1);

    // START held for 20 edges: exactly two frames, one IDLE cycle between them.
    run_frame(1'b0, 8'hC3, -1, 0, 1'b1, 1'b0);
    run_frame(1'b0, 8'h19, -1, 0, 1'b1, 1'b0);
    start0 = 1'b0;
    repeat (3) begin
      expect_out(1'b0, 1'b1, 1'b0, 1'b0);
      step_cycle();
    end

    // Reset while bit 4 is on QH: no DONE, register cleared.
    data = 8'h5C;
    set_lines(data);
    start0 = 1'b1;
    expect_out(1'b0, bit_of(1'b0, data, 0), 1'b1, 1'b0);
    step_cycle();
    start0 = 1'b0;
    for (int k = 1; k < 4; k++) begin
      expect_out(1'b0, bit_of(1'b0, data, k), 1'b1, 1'b0);
      step_cycle();
    end
    RESET = 1'b1;
    expect_out(1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(1'b1, 1'b0, 1'b0, 1'b0);
    step_cycle();
    RESET = 1'b0;
    repeat (3) begin
      expect_out(1'b0, 1'b0, 1'b0, 1'b0);
      step_cycle();
    end
    run_frame(1'b0, 8'h3A, -1, 0, 1'b0, 1'b0);
    run_frame(1'b1, 8'hE6, -1, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ttl_74165_serializer.md
Name: ttl_74165_serializer

Overview:
- Parallel-in, serial-out reader for eight TTL-style lines A..H.
- It is the other end of an 8-input gate bus: it captures the eight lines on request and shifts them out on one wire.
- The datapath core models a 74165 shift register, with latch, shift, SER cascade and clock inhibit.
- A small controller wraps the core and adds a start/busy/done handshake and bit pacing, so a downstream serial receiver or checker can consume frames.

Parameters:
- WIDTH, 8: number of parallel inputs and frame length in bits; the port list is fixed at 8, so only 8 is legal.
- BIT_CYCLES, 1: CLK cycles each bit is held on QH; legal range 1..255.
- MSB_FIRST, 1: 1 means H is shifted out first, as on a 74165; 0 means A first.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- A,B,C,D,E,F,G,H  in  1 each  parallel data lines; A is the LSB, H the MSB.
- SER  in  1  serial cascade input, shifted into the vacated end of the register.
- START  in  1  request a capture-and-shift frame.
- CLK_INH  in  1  pauses shifting and the bit-period counter while high.
- QH  out  1  serial data out.
- QH_N  out  1  complement of QH, always.
- BUSY  out  1  high while a frame is in progress.
- DONE  out  1  one-cycle pulse after the last bit period completes.

Behaviour:
- Reset (RESET high at a rising edge):
  - Shift register cleared to 0, counters cleared, state goes to IDLE.
  - Outputs: QH=0, QH_N=1, BUSY=0, DONE=0.
  - RESET overrides every other input, including mid-frame; the partial frame is abandoned and DONE is not pulsed.
- States:
  - IDLE: BUSY=0, QH holds the last shifted value (0 after reset).
  - SHIFT: BUSY=1.
  - DONE: single cycle, DONE=1, BUSY=0, then back to IDLE.
- IDLE -> SHIFT: START high at an edge.
  - A..H are sampled on that same edge into the register. This is the latch, equivalent to SH/LD low.
  - QH presents the first bit (H if MSB_FIRST, else A) from the next cycle.
  - BUSY rises in that same cycle.
- SHIFT, bit pacing:
  - A bit counter (0..WIDTH-1) and a period counter (0..BIT_CYCLES-1) run.
  - The period counter advances only when CLK_INH=0.
  - When the period counter wraps, the register shifts by one. SER enters the LSB end if MSB_FIRST, else the MSB end.
  - The bit counter increments on each shift.
- SHIFT -> DONE: on the wrap of the final bit's period (bit counter = WIDTH-1).
  - No shift occurs on that final wrap.
  - Frame length is exactly WIDTH*BIT_CYCLES non-inhibited cycles.
- START while BUSY or in DONE: ignored; it is not queued.
  - START in the same cycle DONE is asserted is also ignored.
  - A new frame needs START in IDLE.
- CLK_INH during SHIFT: register, bit counter and period counter all freeze; QH is held; BUSY stays high.
- CLK_INH in IDLE: START is still accepted; loading is not inhibited.
- QH is registered directly from the end stage of the register; there is no combinational path from A..H to QH.
- Latency: START edge -> first bit valid is 1 cycle; START edge -> DONE pulse is WIDTH*BIT_CYCLES+1 cycles when CLK_INH stays 0.

Decomposition:
- Package ttl_serial_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the WIDTH constant of 8;
  - the counter width constant CNT_W = 8.
- Sub-module ttl_74165_core holds the pure 8-bit register.
  - Inputs: load, shift_en, SER, direction, D[7:0].
  - Outputs: QH, QH_N.
- The controller lives in ttl_74165_serializer.

Test Plan:
- Reset check: apply RESET for 2 cycles with A..H=1 and START=1 -> QH=0, QH_N=1, BUSY=0, DONE=0 throughout.
- Basic frame: BIT_CYCLES=1, MSB_FIRST=1, H..A=1011_0010, SER=0, pulse START -> QH sequence 1,0,1,1,0,0,1,0 on cycles 1..8, DONE high at cycle 9, BUSY low at cycle 9.
- Pacing and LSB-first: BIT_CYCLES=3, MSB_FIRST=0, A..H=1,1,0,0,0,0,0,1 -> each bit held 3 cycles in the order 1,1,0,0,0,0,0,1; DONE at cycle 25.
- Inhibit: 8'hA5, CLK_INH high for 4 cycles after the 3rd bit -> QH frozen for those cycles; DONE delayed by exactly 4 cycles (cycle 13).
- Start rules: START held high for 20 cycles -> exactly two frames, with one IDLE cycle between the DONE pulse and the next BUSY. START asserted mid-frame -> no effect.
- Reset mid-frame: RESET at the 4th bit -> next cycle QH=0, BUSY=0, no DONE pulse; a subsequent START runs a full frame correctly.
